// File: rtl/matrix_code_encoder.sv
// Collects a 4x4 byte matrix row-major, builds column parities and per-row XOR checks, presents one frame (out_valid the cycle after the 16th accept, held until out_ready; in_ready low while full).
// Optional MATRIX_CODE_FAULT_INJ_EN adds inj_en/inj_idx/inj_mask to corrupt one stored element after its checks are computed.
module matrix_code_encoder #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*N*DW-1:0]   out_matrix,
  output logic [N*DW-1:0]     out_col_par,
  output logic [N*3*DW-1:0]   out_row_chk
`ifdef MATRIX_CODE_FAULT_INJ_EN
  ,
  input  logic                inj_en,
  input  logic [3:0]          inj_idx,
  input  logic [DW-1:0]       inj_mask
`endif
);

  typedef enum logic {LOAD, FULL} state_t;

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [N*N*DW-1:0]   mat_q, mat_d;
  logic [N*DW-1:0]     col_q, col_d;
  logic [N*3*DW-1:0]   row_q, row_d;
  logic [DW-1:0]       stored;
  int                  r, c;

  // Checks always use the clean in_data; only the stored copy may be corrupted.
`ifdef MATRIX_CODE_FAULT_INJ_EN
  assign stored = (inj_en && (inj_idx == idx_q)) ? (in_data ^ inj_mask) : in_data;
`else
  assign stored = in_data;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mat_d   = mat_q;
    col_d   = col_q;
    row_d   = row_q;
    r       = int'(idx_q[3:2]);
    c       = int'(idx_q[1:0]);
    if (flush) begin
      state_d = LOAD;
      idx_d   = '0;
      mat_d   = '0;
      col_d   = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            mat_d[(N*r+c)*DW +: DW] = stored;
            col_d[c*DW +: DW]       = col_q[c*DW +: DW] ^ in_data;
            if (c != 3) row_d[(3*r+0)*DW +: DW] = row_q[(3*r+0)*DW +: DW] ^ in_data;
            if (c != 2) row_d[(3*r+1)*DW +: DW] = row_q[(3*r+1)*DW +: DW] ^ in_data;
            if (c != 1) row_d[(3*r+2)*DW +: DW] = row_q[(3*r+2)*DW +: DW] ^ in_data;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_d = LOAD;
            mat_d   = '0;
            col_d   = '0;
            row_d   = '0;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      mat_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mat_q   <= mat_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign in_ready    = (state_q == LOAD);
  assign out_valid   = (state_q == FULL);
  assign out_matrix  = mat_q;
  assign out_col_par = col_q;
  assign out_row_chk = row_q;

endmodule

// File: tb/tb_matrix_code_encoder.sv
// Directed bench for matrix_code_encoder: golden frame, hold/backpressure, idle gaps, flush, mid-frame reset.
module tb_matrix_code_encoder;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0]   in_data;
  logic [127:0] out_matrix;
  logic [31:0]  out_col_par;
  logic [95:0]  out_row_chk;
`ifdef MATRIX_CODE_FAULT_INJ_EN
  logic         inj_en;
  logic [3:0]   inj_idx;
  logic [7:0]   inj_mask;
`endif

  always #5 clk = ~clk;

  matrix_code_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_matrix(out_matrix), .out_col_par(out_col_par), .out_row_chk(out_row_chk)
`ifdef MATRIX_CODE_FAULT_INJ_EN
    , .inj_en(inj_en), .inj_idx(inj_idx), .inj_mask(inj_mask)
`endif
  );

  // Hand-computed from 150,200,250,180,60,80,100,72,120,160,200,144,90,120,150,108
  localparam logic [127:0] GOLD_MAT = 128'h6C96785A_90C8A078_4864503C_B4FAC896;
  localparam logic [31:0]  GOLD_COL = 32'h00C04088;
  localparam logic [95:0]  GOLD_ROW = 96'hA04EB4_204810_102408_D8EAA4;

  typedef struct {
    logic       vld;
    logic [7:0] dat;
    logic       exp_ovld;
    logic       exp_irdy;
  } vec_t;

  vec_t tv [32];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] m, input int cnt);
    for (int i = 0; i < cnt; i++) send(m[8*i +: 8]);
  endtask

  task automatic check_frame(input string tag, input logic [127:0] m,
                             input logic [31:0] cp, input logic [95:0] rc);
    chk({tag, "_out_valid"}, {127'd0, out_valid}, 128'd1);
    chk({tag, "_in_ready"},  {127'd0, in_ready},  128'd0);
    chk({tag, "_matrix"},    out_matrix, m);
    chk({tag, "_col_par"},   {96'd0, out_col_par}, {96'd0, cp});
    chk({tag, "_row_chk"},   {32'd0, out_row_chk}, {32'd0, rc});
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
    chk({tag, "_in_ready"},  {127'd0, in_ready},  128'd1);
    chk({tag, "_zero"}, out_matrix | {96'd0, out_col_par} | {32'd0, out_row_chk}, 128'd0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
`ifdef MATRIX_CODE_FAULT_INJ_EN
    inj_en = 1'b0; inj_idx = '0; inj_mask = '0;
`endif
    for (int i = 0; i < 32; i++) begin
      tv[i].vld      = (i % 2 == 0);
      tv[i].dat      = (i % 2 == 0) ? GOLD_MAT[8*(i/2) +: 8] : 8'hEE;
      tv[i].exp_ovld = (i >= 30);
      tv[i].exp_irdy = (i < 30);
    end

    tick(); tick();
    check_empty("reset");
    rst_n = 1'b1;
    tick();

    // Golden frame, held with out_ready low
    send_frame(GOLD_MAT, 16);
    check_frame("golden", GOLD_MAT, GOLD_COL, GOLD_ROW);
    chk("col_par0", {120'd0, out_col_par[7:0]}, 128'h88);
    chk("col_par1", {120'd0, out_col_par[15:8]}, 128'h40);
    chk("row_chk00", {120'd0, out_row_chk[7:0]}, 128'hA4);
    chk("elem11", {120'd0, out_matrix[47:40]}, 128'd80);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_frame("hold", GOLD_MAT, GOLD_COL, GOLD_ROW);
    end
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    check_frame("ignored_in_full", GOLD_MAT, GOLD_COL, GOLD_ROW);
    consume();
    check_empty("consumed");

    send_frame(128'd0, 16);
    check_frame("zeros", 128'd0, 32'd0, 96'd0);
    consume();

    // Idle cycles between accepts must not advance the slot index
    for (int i = 0; i < 32; i++) begin
      in_valid = tv[i].vld;
      in_data  = tv[i].dat;
      tick();
      chk($sformatf("gap_ovld_%0d", i), {127'd0, out_valid}, {127'd0, tv[i].exp_ovld});
      chk($sformatf("gap_irdy_%0d", i), {127'd0, in_ready},  {127'd0, tv[i].exp_irdy});
    end
    in_valid = 1'b0;
    check_frame("gap", GOLD_MAT, GOLD_COL, GOLD_ROW);
    consume();

    // Flush after 7 accepts, with a dropped element in the flush cycle
    send_frame(128'hFFFF_FFFF_FFFF_FFFF_1234_5678_9ABC_DEF0, 7);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_empty("flush_load");
    send_frame(GOLD_MAT, 16);
    check_frame("after_flush", GOLD_MAT, GOLD_COL, GOLD_ROW);

    // Flush with out_ready while full is only a flush
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check_empty("flush_full");

    // Asynchronous reset mid-frame
    send_frame(GOLD_MAT, 10);
    rst_n = 1'b0;
    #2;
    check_empty("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(GOLD_MAT, 16);
    check_frame("after_rst", GOLD_MAT, GOLD_COL, GOLD_ROW);
    consume();

`ifdef MATRIX_CODE_FAULT_INJ_EN
    inj_en = 1'b1; inj_idx = 4'd5; inj_mask = 8'h16;
    send_frame(GOLD_MAT, 16);
    inj_en = 1'b0;
    check_frame("inj", GOLD_MAT ^ (128'h16 << 40), GOLD_COL, GOLD_ROW);
    chk("inj_elem11", {120'd0, out_matrix[47:40]}, 128'd70);
    consume();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
